// File: rtl/speed_sample_sched.sv
// Periodic coherent snapshot of NUM_MOTORS encoder counters; emits one signed
// per-motor count delta per handshake, flagging ticks that land mid-burst.
module speed_sample_sched #(
    parameter int NUM_MOTORS    = 4,
    parameter int CNT_W         = 16,
    parameter int PERIOD_CYCLES = 50000,
    localparam int ID_W         = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1,
    localparam int TICK_W       = $clog2(PERIOD_CYCLES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_MOTORS*CNT_W-1:0] enc_count,
    output logic                        speed_valid,
    input  logic                        speed_ready,
    output logic [CNT_W-1:0]            speed_data,
    output logic [ID_W-1:0]             speed_id,
    output logic                        overrun,
    input  logic                        clear_overrun
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRIME     = 3'd1;
    localparam logic [2:0] WAIT_TICK = 3'd2;
    localparam logic [2:0] SNAP      = 3'd3;
    localparam logic [2:0] EMIT      = 3'd4;

    logic [2:0]                         state;
    logic [TICK_W-1:0]                  tick_cnt;
    logic [ID_W-1:0]                    idx;
    logic                               stop;
    logic [NUM_MOTORS-1:0][CNT_W-1:0]   prev;
    logic [NUM_MOTORS-1:0][CNT_W-1:0]   snap;
    logic [NUM_MOTORS-1:0][CNT_W-1:0]   cur;

    logic              tick;
    logic              last;
    logic              busy;
    logic [TICK_W-1:0] tick_next;

    assign cur       = enc_count;
    assign tick      = (tick_cnt == TICK_W'(PERIOD_CYCLES - 1));
    assign tick_next = tick ? '0 : tick_cnt + TICK_W'(1);
    assign last      = (idx == ID_W'(NUM_MOTORS - 1));
    assign busy      = (state == SNAP) || (state == EMIT);

    assign speed_valid = (state == EMIT);
    assign speed_id    = idx;
    assign speed_data  = snap[idx] - prev[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            idx      <= '0;
            stop     <= 1'b0;
            overrun  <= 1'b0;
            prev     <= '0;
            snap     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (enable) state <= PRIME;
                end
                PRIME: begin
                    prev     <= cur;
                    tick_cnt <= '0;
                    state    <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_next;
                        if (tick) state <= SNAP;
                    end
                end
                SNAP: begin
                    snap     <= cur;
                    idx      <= '0;
                    tick_cnt <= tick_next;
                    if (!enable) stop <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: begin
                    tick_cnt <= tick_next;
                    if (!enable) stop <= 1'b1;
                    if (speed_ready) begin
                        prev[idx] <= snap[idx];
                        if (last) begin
                            idx <= '0;
                            // A disable seen anywhere in the burst ends the session here
                            if (stop || !enable) begin
                                stop     <= 1'b0;
                                tick_cnt <= '0;
                                state    <= IDLE;
                            end else begin
                                state <= WAIT_TICK;
                            end
                        end else begin
                            idx <= idx + ID_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (busy && tick)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_speed_sample_sched.sv
// Bench for speed_sample_sched: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_speed_sample_sched;

    localparam int N = 4;
    localparam int W = 16;
    localparam int P = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [N-1:0][W-1:0] cnt_arr = '0;
    logic             speed_valid;
    logic             speed_ready = 1'b0;
    logic [W-1:0]     speed_data;
    logic [1:0]       speed_id;
    logic             overrun;
    logic             clear_overrun = 1'b0;

    speed_sample_sched #(.NUM_MOTORS(N), .CNT_W(W), .PERIOD_CYCLES(P)) dut (
        .clk(clk), .reset(reset), .enable(enable), .enc_count(cnt_arr),
        .speed_valid(speed_valid), .speed_ready(speed_ready),
        .speed_data(speed_data), .speed_id(speed_id),
        .overrun(overrun), .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // model: session flags, cycles since priming, pending-result queue
    bit          m_idle = 1'b1, m_prime = 1'b0, m_snap = 1'b0, m_stop = 1'b0, m_ovr = 1'b0;
    int unsigned m_age = 0;
    logic [W-1:0] m_base [N];
    logic [W-1:0] m_snapv[N];
    int          m_q[$];

    int          log_id[$];
    logic [W-1:0] log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit busy, tick, drop;
        int id;
        if (reset) begin
            m_idle = 1; m_prime = 0; m_snap = 0; m_stop = 0; m_ovr = 0; m_age = 0;
            m_q.delete();
            for (int i = 0; i < N; i++) begin m_base[i] = '0; m_snapv[i] = '0; end
            return;
        end
        busy = m_snap || (m_q.size() > 0);
        tick = !m_idle && !m_prime && (m_age % P == P - 1);
        drop = tick && busy;
        if (m_idle) begin
            if (enable) begin m_idle = 0; m_prime = 1; end
        end else if (m_prime) begin
            for (int i = 0; i < N; i++) m_base[i] = cnt_arr[i];
            m_prime = 0;
            m_age = 0;
        end else if (!busy && !enable) begin
            m_idle = 1;
        end else begin
            if (!enable) m_stop = 1;
            m_age++;
            if (m_snap) begin
                for (int i = 0; i < N; i++) begin m_snapv[i] = cnt_arr[i]; m_q.push_back(i); end
                m_snap = 0;
            end else if (busy && speed_ready) begin
                id = m_q.pop_front();
                m_base[id] = m_snapv[id];
                if (m_q.size() == 0 && m_stop) begin m_idle = 1; m_stop = 0; end
            end else if (!busy && tick) begin
                m_snap = 1;
            end
        end
        if (drop) m_ovr = 1;
        else if (clear_overrun) m_ovr = 0;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", speed_valid, m_q.size() > 0);
            chk("overrun", overrun, m_ovr);
            if (m_q.size() > 0) begin
                chk("id", speed_id, m_q[0]);
                chk("data", speed_data, W'(m_snapv[m_q[0]] - m_base[m_q[0]]));
            end
            if (speed_valid && speed_ready) begin
                log_id.push_back(speed_id);
                log_data.push_back(speed_data);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name, input int exp_n, input bit chk_n);
        int n;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!speed_valid && n < 40);
        if (!speed_valid) begin
            tests++; fails++;
            $display("FAIL %s: no speed_valid within %0d cycles", name, n);
        end else if (chk_n) begin
            chk(name, n, exp_n);
        end
    endtask

    task automatic clear_log();
        log_id.delete();
        log_data.delete();
    endtask

    logic [W-1:0] held;

    initial begin
        cyc(2);
        chk_on = 1'b1;
        chk("rst_valid", speed_valid, 0);
        chk("rst_data", speed_data, 0);
        chk("rst_id", speed_id, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;

        // basic deltas: prime on {100,200,300,400}, snapshot {110,190,300,65535}
        cnt_arr = {16'd400, 16'd300, 16'd200, 16'd100};
        enable = 1'b1;
        speed_ready = 1'b1;
        cyc(2);
        cnt_arr = {16'd65535, 16'd300, 16'd190, 16'd110};
        clear_log();
        wait_valid("first_latency", 11, 1);
        cyc(3);
        chk("burst_len", log_id.size(), 4);
        if (log_id.size() == 4) begin
            chk("d0", log_data[0], 16'd10);
            chk("d1", log_data[1], 16'hFFF6);
            chk("d2", log_data[2], 16'd0);
            chk("d3", log_data[3], 16'hFE6F);
            chk("id3", log_id[3], 3);
        end
        cyc(1);

        // wrap across zero on motor 0
        cnt_arr[0] = 16'hFFFE;
        wait_valid("wrap_a", 0, 0);
        cyc(4);
        cnt_arr[0] = 16'h0003;
        clear_log();
        wait_valid("wrap_b", 0, 0);
        chk("wrap_data", log_data.size() > 0 ? log_data[0] : 16'hDEAD, 16'd5);
        cyc(4);

        // backpressure past a tick -> overrun, held data, then clear
        speed_ready = 1'b0;
        wait_valid("bp_valid", 0, 0);
        held = speed_data;
        cyc(15);
        chk("bp_valid_held", speed_valid, 1);
        chk("bp_data_held", speed_data, held);
        chk("bp_id_held", speed_id, 0);
        chk("bp_overrun", overrun, 1);
        speed_ready = 1'b1;
        cyc(4);
        clear_overrun = 1'b1;
        cyc(1);
        clear_overrun = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // reset with id 2 pending
        wait_valid("pre_rst", 0, 0);
        cyc(2);
        chk("pending_id2", speed_id, 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_valid", speed_valid, 0);
        chk("mid_rst_data", speed_data, 0);
        chk("mid_rst_id", speed_id, 0);
        chk("mid_rst_ovr", overrun, 0);
        wait_valid("post_rst_latency", 13, 1);
        cyc(4);

        // disable mid-burst: burst completes, then idle; re-enable re-primes
        clear_log();
        wait_valid("dis_valid", 0, 0);
        enable = 1'b0;
        cyc(4);
        chk("dis_burst_len", log_id.size(), 4);
        if (log_id.size() == 4) chk("dis_last_id", log_id[3], 3);
        cyc(3);
        chk("dis_idle", speed_valid, 0);
        enable = 1'b1;
        wait_valid("reenable_latency", 13, 1);
        cyc(4);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 59) != 0);
            speed_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            clear_overrun = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < N; i++)
                cnt_arr[i] = cnt_arr[i] + W'($urandom_range(0, 800)) - W'(400);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
